// File: rtl/count_pattern_detector_pkg.sv
// Shared types and constants for the counter-stream pattern detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_pattern_detector_pkg;

   localparam int SYM_W = 2;

   // State value equals the length of the pattern prefix matched so far.
   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2
   } state_t;

   localparam logic [SYM_W-1:0] DEF_P0 = 2'b01;
   localparam logic [SYM_W-1:0] DEF_P1 = 2'b10;
   localparam logic [SYM_W-1:0] DEF_P2 = 2'b11;

endpackage

// File: rtl/count_pattern_detector_if.sv
// Symbol-in / match-out bundle between the counter stage and the detector.
// Latency: n/a (wiring only).
// Backpressure: none; the symbol qualifier is a plain valid with no ready.
// Ports: i_sym_valid/i_sym/i_clear toward the detector; o_match, o_match_count,
//        o_sat, o_prefix back from it.
interface count_pattern_detector_if
   import count_pattern_detector_pkg::*;
#(
   parameter int CNT_W = 8
);
   logic             i_sym_valid;
   logic [SYM_W-1:0] i_sym;
   logic             i_clear;
   logic             o_match;
   logic [CNT_W-1:0] o_match_count;
   logic             o_sat;
   logic [1:0]       o_prefix;

   // Driver side (counter stage / bench).
   modport master (
      output i_sym_valid, i_sym, i_clear,
      input  o_match, o_match_count, o_sat, o_prefix
   );

   // Detector side.
   modport slave (
      input  i_sym_valid, i_sym, i_clear,
      output o_match, o_match_count, o_sat, o_prefix
   );
endinterface

// File: rtl/count_pattern_detector_sat_counter.sv
// Saturating event tally with a sticky flag raised when the top value is reached.
// Latency: one clock from i_inc/i_clr to o_count/o_sat.
// Backpressure: none; i_clr has priority over i_inc on the same edge.
// Ports: i_clk, i_rst_n (async, active-low), i_inc, i_clr, o_count[W], o_sat.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_count,
   output logic         o_sat
);
   localparam logic [W-1:0] MAX = '1;
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_count;
   logic         r_sat;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (i_clr) begin
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (i_inc && (r_count != MAX)) begin
         r_count <= r_count + ONE;
         // Flag rises together with the count reaching its top value.
         if (r_count == (MAX - ONE)) begin
            r_sat <= 1'b1;
         end
      end
   end

   assign o_count = r_count;
   assign o_sat   = r_sat;

endmodule

// File: rtl/count_pattern_detector.sv
// Detects a 3-symbol sequence (overlaps included) in the counter's output stream.
// Latency: one clock from accepted symbol to o_match / updated o_match_count.
// Backpressure: none; one symbol per clock whenever i_sym_valid is high.
// Ports: i_clk, i_rst_n (async, active-low), bus (slave modport: i_sym_valid,
//        i_sym, i_clear in; o_match, o_match_count, o_sat, o_prefix out).
module count_pattern_detector
   import count_pattern_detector_pkg::*;
#(
   parameter logic [SYM_W-1:0] P0    = DEF_P0,
   parameter logic [SYM_W-1:0] P1    = DEF_P1,
   parameter logic [SYM_W-1:0] P2    = DEF_P2,
   parameter int               CNT_W = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   count_pattern_detector_if.slave bus
);
   state_t r_state;
   state_t w_state_nxt;
   logic   r_match;
   logic   w_hit;

   // Next state is the longest suffix of (matched prefix, new symbol) that is
   // itself a prefix of the pattern, tried longest first. In S1 the previous
   // symbol is P0 and in S2 it is P1, so the length-2 test reduces to the
   // comparisons below.
   always_comb begin
      w_state_nxt = r_state;
      w_hit       = 1'b0;
      if (bus.i_sym_valid) begin
         w_hit = (r_state == S2) && (bus.i_sym == P2);
         if (((r_state == S1) && (bus.i_sym == P1)) ||
             ((r_state == S2) && (P1 == P0) && (bus.i_sym == P1))) begin
            w_state_nxt = S2;
         end else if (bus.i_sym == P0) begin
            w_state_nxt = S1;
         end else begin
            w_state_nxt = S0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S0;
         r_match <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_match <= w_hit;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_tally (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (w_hit),
      .i_clr   (bus.i_clear),
      .o_count (bus.o_match_count),
      .o_sat   (bus.o_sat)
   );

   assign bus.o_match  = r_match;
   assign bus.o_prefix = r_state;

endmodule

// File: doc/count_pattern_detector.md
# count_pattern_detector

Downstream consumer of the two-bit counter stage. Watches the counter's 2-bit output stream and the counter's enable, and detects a parameterised three-symbol sequence, overlapping occurrences included. Emits a one-cycle match pulse and keeps a saturating tally of matches. Sits between the counter and the board-level indicator logic.

## Interface
- P0, default 2'b01: first pattern symbol
- P1, default 2'b10: second pattern symbol
- P2, default 2'b11: third pattern symbol
- CNT_W, default 8: width of match tally
- clock  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-low reset
- sym_valid  in  1  symbol qualifier; driven from the counter's En
- sym  in  2  symbol; driven from the counter's Counter_Out
- clear  in  1  synchronous clear of tally and sat flag
- match  out  1  registered one-cycle pulse on pattern completion
- match_count  out  CNT_W  saturating number of matches since reset/clear
- sat  out  1  sticky flag; tally has reached 2^CNT_W-1
- prefix  out  2  current matched-prefix length (FSM state)

## Operation
- FSM states encode matched-prefix length: S0 (none), S1 (P0 seen), S2 (P0,P1 seen). Encoded 0,1,2. prefix outputs the state.
- A symbol is accepted only on an edge with sym_valid=1. With sym_valid=0, state, tally and sat hold, and match is 0 next cycle.
- Next-state rule on an accepted symbol s:
  - Form the string w = (matched prefix) followed by s.
  - If w equals P0,P1,P2, flag a match.
  - Next state is the longest proper suffix of w that is a prefix of P0,P1,P2, with length at most 2.
  - Checks run in order: length 2, then 1, then 0.
- This gives KMP-style overlap:
  - Pattern 00,00,00 after a match goes to S2.
  - Default pattern after a match goes to S0.
  - Pattern 01,01,10 in S2 on 01 stays in S2.
- On a match:
  - match=1 for exactly the following cycle.
  - match_count increments by 1 unless already at 2^CNT_W-1. At that value it holds, and sat is set.
- clear=1: match_count and sat go to 0 at the edge. FSM state and match are unaffected.
- clear and match on the same edge: clear wins for the tally (result 0). match still pulses.
- Reset low, at any time including mid-sequence, forces immediately: state S0, match 0, match_count 0, sat 0, prefix 0.
- Reset release: the first edge with Reset=1 may accept a symbol.

## Timing
- Reset values: match=0, match_count=0, sat=0, prefix=0.
- Latency: one clock. The symbol accepted at edge N completes a match, and match is high from edge N to edge N+1.
- match_count shows the new value in the same cycle that match is high.
- Back-to-back matches (overlapping patterns) give match high on consecutive cycles.
- No combinational path from inputs to outputs; all outputs are registered.
- Throughput: one symbol per clock.

## Structure
- Shared package holds:
  - SYM_W = 2
  - state encodings S0/S1/S2
  - default pattern constants
- The next-state/suffix function is a combinational block inside the module.
- One sub-module, sat_counter (parameter W; inputs inc, clr; outputs count, sat), implements the saturating tally and sticky flag.
- FSM plus sat_counter totals roughly 150–250 lines.

## Test plan
- Default pattern, sym_valid=1, stream 00,01,10,11,00,01,10,11: match high after the 4th and 8th symbols only, match_count=2, prefix returns to 0 after each match.
- P0=P1=P2=00, stream 00 ×5: match on symbols 3, 4 and 5 (three consecutive cycles), match_count=3, prefix=2 after each.
- P0=01, P1=01, P2=10, stream 01,01,01,10: prefix 1,2,2, then match on the 4th symbol; match_count=1.
- Default pattern with sym_valid=0 gaps inserted between 01, 10 and 11: state holds across the gaps, a single match occurs on acceptance of 11, and match is never high during a gap cycle.
- CNT_W=2, 4 default-pattern matches: match_count 1,2,3,3, and sat=1 from the third match. Then clear=1 on a match edge: match=1, match_count=0, sat=0.
- Reset low mid-sequence (state S2): all outputs 0 immediately. After release, stream 11 produces no match, and 01,10,11 produces match with match_count=1.
